// File: rtl/alu_pkg.sv
// Shared ALU control definitions: ALUCtrl codes, ALUOp classes, funct7 constants
// and the issue FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_XOR    = 4'b0001;
  localparam logic [3:0] ALU_SLL    = 4'b0010;
  localparam logic [3:0] ALU_ADD    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0100;
  localparam logic [3:0] ALU_MUL    = 4'b0101;
  localparam logic [3:0] ALU_ADDI   = 4'b0110;
  localparam logic [3:0] ALU_SRAI   = 4'b0111;
  localparam logic [3:0] ALU_LS_ADD = 4'b1000;
  localparam logic [3:0] ALU_BR_SUB = 4'b1001;

  localparam logic [1:0] OP_LS = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_I  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder producing the ALUCtrl code and illegal flag.
// The MUL decode and o_is_mul port exist only when ALU_CTRL_MUL_EN is defined.
import alu_pkg::*;

module alu_ctrl_decode (
  input  logic [1:0] i_alu_op,
  input  logic [9:0] i_funct,
  output logic [3:0] o_code,
`ifdef ALU_CTRL_MUL_EN
  output logic       o_is_mul,
`endif
  output logic       o_illegal
);

  logic [6:0] w_f7;
  logic [2:0] w_f3;

  assign w_f7 = i_funct[9:3];
  assign w_f3 = i_funct[2:0];

  // Illegal ops fall through with the harmless ADD code.
  always_comb begin
    o_code    = ALU_ADD;
    o_illegal = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    o_is_mul  = 1'b0;
`endif
    case (i_alu_op)
      OP_LS: o_code = ALU_LS_ADD;
      OP_BR: o_code = ALU_BR_SUB;
      OP_R: begin
        case ({w_f7, w_f3})
          {F7_BASE, 3'b111}: o_code = ALU_AND;
          {F7_BASE, 3'b100}: o_code = ALU_XOR;
          {F7_BASE, 3'b001}: o_code = ALU_SLL;
          {F7_BASE, 3'b000}: o_code = ALU_ADD;
          {F7_ALT,  3'b000}: o_code = ALU_SUB;
`ifdef ALU_CTRL_MUL_EN
          {F7_MUL,  3'b000}: begin
            o_code   = ALU_MUL;
            o_is_mul = 1'b1;
          end
`endif
          default: o_illegal = 1'b1;
        endcase
      end
      default: begin
        if (w_f3 == 3'b000) begin
          o_code = ALU_ADDI;
        end else if (w_f3 == 3'b101 && w_f7 == F7_ALT) begin
          o_code = ALU_SRAI;
        end else begin
          o_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// EX-stage issue controller: registers the decoded ALUCtrl code and sequences
// multi-cycle MUL occupancy. MUL support is built only with ALU_CTRL_MUL_EN.
import alu_pkg::*;

module alu_ctrl_issue #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] ALUOp_i,
  input  logic [9:0] funct_i,
  input  logic       flush_i,
  output logic       ready_o,
  output logic [3:0] ALUCtrl_o,
  output logic       ctrl_valid_o,
  output logic       stall_o,
  output logic       illegal_o
);

  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("alu_ctrl_issue: MUL_LAT must be in 1..16");
  end

  logic [3:0] w_code_p0;
  logic       w_illegal_p0;
  logic       w_ready;
  logic       w_accept_p0;

  logic [3:0] r_code_p1;
  logic       r_vld_p1;
  logic       r_illegal_p1;

  assign w_accept_p0 = valid_i && w_ready && !flush_i;

`ifdef ALU_CTRL_MUL_EN
  localparam logic [3:0] LP_CNT_LOAD = 4'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  logic       w_is_mul_p0;
  alu_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  alu_ctrl_decode u_decode (
    .i_alu_op  (ALUOp_i),
    .i_funct   (funct_i),
    .o_code    (w_code_p0),
    .o_is_mul  (w_is_mul_p0),
    .o_illegal (w_illegal_p0)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_p0 && w_is_mul_p0 && (MUL_LAT > 1)) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = LP_CNT_LOAD;
        end
      end
      default: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
    endcase
  end

  assign w_ready = (r_state == ST_IDLE);
  assign stall_o = (r_state == ST_BUSY);
`else
  alu_ctrl_decode u_decode (
    .i_alu_op  (ALUOp_i),
    .i_funct   (funct_i),
    .o_code    (w_code_p0),
    .o_illegal (w_illegal_p0)
  );

  assign w_ready = 1'b1;
  assign stall_o = 1'b0;
`endif

  // p0 -> p1: issue register seen by the ALU
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_code_p1    <= ALU_AND;
      r_vld_p1     <= 1'b0;
      r_illegal_p1 <= 1'b0;
    end else begin
      r_vld_p1     <= w_accept_p0 && !w_illegal_p0;
      r_illegal_p1 <= w_accept_p0 && w_illegal_p0;
      if (w_accept_p0) begin
        r_code_p1 <= w_code_p0;
      end
    end
  end

  assign ready_o      = w_ready;
  assign ALUCtrl_o    = r_code_p1;
  assign ctrl_valid_o = r_vld_p1;
  assign illegal_o    = r_illegal_p1;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Randomized scoreboard bench for alu_ctrl_issue: a cycle-level reference model
// predicts every post-edge output set, and a monitor compares after each edge.
module tb_alu_ctrl_issue;

  localparam int LAT = 3;
`ifdef ALU_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [1:0] ALUOp_i = 2'b00;
  logic [9:0] funct_i = 10'd0;
  logic       flush_i = 1'b0;
  logic       ready_o;
  logic [3:0] ALUCtrl_o;
  logic       ctrl_valid_o;
  logic       stall_o;
  logic       illegal_o;

  alu_ctrl_issue #(.MUL_LAT(LAT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ALUOp_i      (ALUOp_i),
    .funct_i      (funct_i),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .ALUCtrl_o    (ALUCtrl_o),
    .ctrl_valid_o (ctrl_valid_o),
    .stall_o      (stall_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] code;
    logic       vld;
    logic       ill;
    logic       stall;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model state: cycle index, first cycle the issue slot is free again, last code.
  int         m_cyc  = 0;
  int         m_free = 0;
  logic [3:0] m_code = 4'b0000;

  function automatic void ref_decode(input logic [1:0] op, input logic [9:0] fn,
                                     output logic [3:0] code, output bit ill,
                                     output bit is_mul);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = fn[9:3];
    f3 = fn[2:0];
    code = 4'b0011;
    ill = 1'b0;
    is_mul = 1'b0;
    if (op == 2'b00) code = 4'b1000;
    else if (op == 2'b01) code = 4'b1001;
    else if (op == 2'b10) begin
      if      (f7 == 7'b0000000 && f3 == 3'b111) code = 4'b0000;
      else if (f7 == 7'b0000000 && f3 == 3'b100) code = 4'b0001;
      else if (f7 == 7'b0000000 && f3 == 3'b001) code = 4'b0010;
      else if (f7 == 7'b0000000 && f3 == 3'b000) code = 4'b0011;
      else if (f7 == 7'b0100000 && f3 == 3'b000) code = 4'b0100;
      else if (f7 == 7'b0000001 && f3 == 3'b000 && MUL_EN) begin
        code = 4'b0101;
        is_mul = 1'b1;
      end else ill = 1'b1;
    end else begin
      if (f3 == 3'b000) code = 4'b0110;
      else if (f3 == 3'b101 && f7 == 7'b0100000) code = 4'b0111;
      else ill = 1'b1;
    end
  endfunction

  task automatic drive(input bit rst, input bit v, input bit fl,
                       input logic [1:0] op, input logic [9:0] fn);
    exp_t       e;
    logic [3:0] code;
    bit         ill, is_mul, acc;
    @(negedge clk_i);
    rst_i = rst; valid_i = v; flush_i = fl; ALUOp_i = op; funct_i = fn;
    ref_decode(op, fn, code, ill, is_mul);
    if (rst) begin
      m_code = 4'b0000;
      m_free = 0;
      e.vld = 1'b0;
      e.ill = 1'b0;
    end else begin
      acc = v && (m_cyc >= m_free) && !fl;
      if (acc) begin
        m_code = code;
        if (is_mul && LAT > 1) m_free = m_cyc + LAT;
      end else if (fl && m_cyc < m_free) begin
        m_free = m_cyc + 1;
      end
      e.vld = acc && !ill;
      e.ill = acc && ill;
    end
    e.code  = m_code;
    e.stall = (m_cyc + 1 < m_free);
    e.rdy   = !e.stall;
    q.push_back(e);
    m_cyc++;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, m_cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ALUCtrl_o",    ALUCtrl_o,             e.code);
        check("ctrl_valid_o", {3'b000, ctrl_valid_o}, {3'b000, e.vld});
        check("illegal_o",    {3'b000, illegal_o},    {3'b000, e.ill});
        check("stall_o",      {3'b000, stall_o},      {3'b000, e.stall});
        check("ready_o",      {3'b000, ready_o},      {3'b000, e.rdy});
      end
    end
  end

  localparam logic [9:0] FN_SUB  = {7'b0100000, 3'b000};
  localparam logic [9:0] FN_MUL  = {7'b0000001, 3'b000};
  localparam logic [9:0] FN_ADD  = {7'b0000000, 3'b000};
  localparam logic [9:0] FN_BAD  = {7'b0000000, 3'b101};
  localparam logic [9:0] FN_SRAI = {7'b0100000, 3'b101};

  initial begin : stim
    logic [6:0] f7;
    logic [9:0] fn;
    drive(1, 0, 0, 2'b00, 10'd0);
    drive(1, 0, 0, 2'b00, 10'd0);
    drive(0, 0, 0, 2'b00, 10'd0);
    drive(0, 1, 0, 2'b10, FN_SUB);
    drive(0, 1, 0, 2'b00, 10'd0);
    drive(0, 0, 0, 2'b00, 10'd0);
    drive(0, 1, 0, 2'b10, FN_MUL);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 2'b10, FN_ADD);
    drive(0, 1, 0, 2'b11, FN_BAD);
    drive(0, 1, 0, 2'b11, FN_SRAI);
    drive(0, 1, 0, 2'b10, FN_MUL);
    drive(0, 1, 1, 2'b10, FN_ADD);
    drive(0, 0, 0, 2'b00, 10'd0);
    drive(0, 1, 0, 2'b10, FN_MUL);
    drive(1, 1, 0, 2'b01, 10'd0);
    drive(0, 1, 1, 2'b01, 10'd0);
    drive(0, 0, 0, 2'b00, 10'd0);
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      fn = {f7, 3'($urandom)};
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0), 2'($urandom), fn);
    end
    drive(0, 0, 0, 2'b00, 10'd0);
    repeat (4) @(posedge clk_i);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
